// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory stage and its SRAM controller.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LO,
        HI,
        DONE
    } mem_state_t;

    localparam logic [31:0]  DEFAULT_ADDR_OFFSET = 32'd1024;
    localparam int unsigned  DEFAULT_SRAM_ADDR_W = 18;
    localparam int unsigned  WAIT_CNT_W          = 4;

endpackage

// File: rtl/gen_register.sv
// Generic load-enabled register with synchronous active-high reset.
module gen_register #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_stage_sram_ctrl_wait_counter.sv
// Per-half-word wait counter; tc flags the last cycle of a half-word access.
module sram_wait_counter
    import mem_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    logic [WAIT_CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + WAIT_CNT_W'(1);
        end
    end

    assign tc = (count == WAIT_CNT_W'(WAIT_CYCLES - 1));

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// Memory stage: word LDR/STR over a 16-bit SRAM as two half-word accesses,
// stalling upstream via freeze, followed by the MEM/WB pipeline register.
module mem_stage_sram_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] ADDR_OFFSET = DEFAULT_ADDR_OFFSET,
    parameter int unsigned SRAM_ADDR_W = DEFAULT_SRAM_ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   WB_en_in,
    input  logic                   MEM_R_EN_in,
    input  logic                   MEM_W_EN_in,
    input  logic [31:0]            ALU_result_in,
    input  logic [31:0]            ST_val_in,
    input  logic [3:0]             Dest_in,
    output logic                   freeze,
    output logic                   WB_en,
    output logic                   MEM_R_EN,
    output logic [31:0]            ALU_result,
    output logic [31:0]            Mem_read_value,
    output logic [3:0]             Dest,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic [15:0]            SRAM_DQ_out,
    output logic                   SRAM_DQ_oe,
    input  logic [15:0]            SRAM_DQ_in,
    output logic                   SRAM_WE_N
);

    mem_state_t             state, next_state;
    logic                   mem_req, is_store, tc, cnt_clr, cnt_inc, load_done;
    logic [31:0]            byte_off;
    logic [SRAM_ADDR_W-1:0] lo_addr, hi_addr;
    logic [15:0]            lo_buf, hi_buf;
    logic [1:0]             wb_ctrl_d;
    logic                   unused_addr_bits;

    assign mem_req  = MEM_R_EN_in | MEM_W_EN_in;
    assign is_store = MEM_W_EN_in & ~MEM_R_EN_in;

    // Half-word address = word index * 2 (+1 for the high half), wrapping at SRAM_ADDR_W.
    assign byte_off         = ALU_result_in - ADDR_OFFSET;
    assign lo_addr          = {byte_off[SRAM_ADDR_W:2], 1'b0};
    assign hi_addr          = {byte_off[SRAM_ADDR_W:2], 1'b1};
    assign unused_addr_bits = ^{byte_off[31:SRAM_ADDR_W+1], byte_off[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        freeze     = 1'b0;
        case (state)
            IDLE: begin
                if (mem_req) begin
                    next_state = LO;
                    freeze     = 1'b1;
                end
            end
            LO: begin
                freeze = 1'b1;
                if (tc) next_state = HI;
            end
            HI: begin
                freeze = 1'b1;
                if (tc) next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign cnt_inc = (state == LO) || (state == HI);
    assign cnt_clr = !cnt_inc || tc;

    sram_wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait_counter (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (cnt_inc),
        .tc  (tc)
    );

    // Bus signals are registered from next_state so they are valid throughout each LO/HI cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            SRAM_ADDR   <= '0;
            SRAM_DQ_out <= '0;
            SRAM_DQ_oe  <= 1'b0;
            SRAM_WE_N   <= 1'b1;
        end else begin
            case (next_state)
                LO: begin
                    SRAM_ADDR  <= lo_addr;
                    SRAM_WE_N  <= ~is_store;
                    SRAM_DQ_oe <= is_store;
                    if (is_store) SRAM_DQ_out <= ST_val_in[15:0];
                end
                HI: begin
                    SRAM_ADDR  <= hi_addr;
                    SRAM_WE_N  <= ~is_store;
                    SRAM_DQ_oe <= is_store;
                    if (is_store) SRAM_DQ_out <= ST_val_in[31:16];
                end
                default: begin
                    SRAM_WE_N  <= 1'b1;
                    SRAM_DQ_oe <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lo_buf <= '0;
            hi_buf <= '0;
        end else begin
            if (state == LO && tc) lo_buf <= SRAM_DQ_in;
            if (state == HI && tc) hi_buf <= SRAM_DQ_in;
        end
    end

    // Control bits load every edge so a stall writes a bubble; data fields hold while frozen.
    assign wb_ctrl_d = freeze ? 2'b00 : {WB_en_in, MEM_R_EN_in};
    assign load_done = (state == DONE) && MEM_R_EN_in;

    gen_register #(.WIDTH(2)) u_wb_ctrl (
        .clk (clk),
        .rst (rst),
        .ld  (1'b1),
        .d   (wb_ctrl_d),
        .q   ({WB_en, MEM_R_EN})
    );

    gen_register #(.WIDTH(36)) u_wb_data (
        .clk (clk),
        .rst (rst),
        .ld  (~freeze),
        .d   ({ALU_result_in, Dest_in}),
        .q   ({ALU_result, Dest})
    );

    gen_register #(.WIDTH(32)) u_wb_read (
        .clk (clk),
        .rst (rst),
        .ld  (load_done),
        .d   ({hi_buf, lo_buf}),
        .q   (Mem_read_value)
    );

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Scoreboard bench for mem_stage_sram_ctrl: word-level memory model, random
// instruction stream, per-cycle SRAM bus checks and MEM/WB retire checks.
module tb_mem_stage_sram_ctrl;

    localparam int unsigned W    = 3;
    localparam logic [31:0] OFFS = 32'h400;
    localparam int unsigned AW   = 18;

    logic          clk = 1'b0;
    logic          rst;
    logic          WB_en_in, MEM_R_EN_in, MEM_W_EN_in;
    logic [31:0]   ALU_result_in, ST_val_in;
    logic [3:0]    Dest_in;
    logic          freeze, WB_en, MEM_R_EN;
    logic [31:0]   ALU_result, Mem_read_value;
    logic [3:0]    Dest;
    logic [AW-1:0] SRAM_ADDR;
    logic [15:0]   SRAM_DQ_out, SRAM_DQ_in;
    logic          SRAM_DQ_oe, SRAM_WE_N;

    always #5 clk = ~clk;

    mem_stage_sram_ctrl #(
        .WAIT_CYCLES (W),
        .ADDR_OFFSET (OFFS),
        .SRAM_ADDR_W (AW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .WB_en_in       (WB_en_in),
        .MEM_R_EN_in    (MEM_R_EN_in),
        .MEM_W_EN_in    (MEM_W_EN_in),
        .ALU_result_in  (ALU_result_in),
        .ST_val_in      (ST_val_in),
        .Dest_in        (Dest_in),
        .freeze         (freeze),
        .WB_en          (WB_en),
        .MEM_R_EN       (MEM_R_EN),
        .ALU_result     (ALU_result),
        .Mem_read_value (Mem_read_value),
        .Dest           (Dest),
        .SRAM_ADDR      (SRAM_ADDR),
        .SRAM_DQ_out    (SRAM_DQ_out),
        .SRAM_DQ_oe     (SRAM_DQ_oe),
        .SRAM_DQ_in     (SRAM_DQ_in),
        .SRAM_WE_N      (SRAM_WE_N)
    );

    function automatic logic [15:0] init_half(input int unsigned a);
        return 16'(a * 32'h9E37) ^ 16'h5A5A;
    endfunction

    // Physical half-word SRAM seen by the DUT
    logic [15:0] sram [0:(1<<AW)-1];
    initial for (int i = 0; i < (1 << AW); i++) sram[i] = init_half(i);
    assign SRAM_DQ_in = sram[SRAM_ADDR];
    always @(posedge clk) if (!SRAM_WE_N) sram[SRAM_ADDR] <= SRAM_DQ_out;

    // Reference: word-addressed memory, unwritten words hold the initial pattern
    logic [31:0] ref_word [int unsigned];
    function automatic logic [31:0] ref_read(input int unsigned w);
        if (ref_word.exists(w)) return ref_word[w];
        return {init_half(2 * w + 1), init_half(2 * w)};
    endfunction

    typedef struct {
        logic        wb;
        logic        mr;
        logic [31:0] alu;
        logic [3:0]  dest;
        logic [31:0] mrv;
    } exp_t;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;
    bit          mon_en = 0;
    bit          prev_valid = 0;
    logic        prev_freeze = 1'b0;
    logic [31:0] exp_mrv = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: each edge with freeze low retires one instruction; edges with freeze high insert a bubble.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && prev_valid) begin
            if (prev_freeze) begin
                check("bubble_wb_en", WB_en, 0);
                check("bubble_mem_r_en", MEM_R_EN, 0);
            end else if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL retire_unexpected: got retire expected none at %0t", $time);
            end else begin
                e = sb.pop_front();
                check("wb_en", WB_en, e.wb);
                check("mem_r_en", MEM_R_EN, e.mr);
                check("alu_result", ALU_result, e.alu);
                check("dest", Dest, e.dest);
                check("mem_read_value", Mem_read_value, e.mrv);
            end
        end
        prev_valid  = mon_en;
        prev_freeze = freeze;
    end

    task automatic reset_checks(input string tag);
        check({tag, "_wb_en"}, WB_en, 0);
        check({tag, "_mem_r_en"}, MEM_R_EN, 0);
        check({tag, "_alu_result"}, ALU_result, 0);
        check({tag, "_mem_read_value"}, Mem_read_value, 0);
        check({tag, "_dest"}, Dest, 0);
        check({tag, "_we_n"}, SRAM_WE_N, 1);
        check({tag, "_dq_oe"}, SRAM_DQ_oe, 0);
        check({tag, "_sram_addr"}, SRAM_ADDR, 0);
        check({tag, "_dq_out"}, SRAM_DQ_out, 0);
        check({tag, "_freeze"}, freeze, 0);
    endtask

    // Expected SRAM bus during stall cycle c of an access (c=0 is the request cycle).
    task automatic bus_check(input int unsigned c, input logic store, input logic [AW-1:0] lo,
                             input logic [31:0] st);
        if (c == 0 || c == 2 * W + 1) begin
            check("idle_we_n", SRAM_WE_N, 1);
            check("idle_dq_oe", SRAM_DQ_oe, 0);
        end else if (c <= 2 * W) begin
            check("bus_addr", SRAM_ADDR, (c <= W) ? lo : lo + AW'(1));
            check("bus_we_n", SRAM_WE_N, !store);
            check("bus_dq_oe", SRAM_DQ_oe, store);
            if (store) check("bus_dq_out", SRAM_DQ_out, (c <= W) ? st[15:0] : st[31:16]);
        end
    endtask

    task automatic drive(input logic wb, input logic r, input logic w, input logic [31:0] alu,
                         input logic [31:0] st, input logic [3:0] dest);
        WB_en_in      = wb;
        MEM_R_EN_in   = r;
        MEM_W_EN_in   = w;
        ALU_result_in = alu;
        ST_val_in     = st;
        Dest_in       = dest;
    endtask

    task automatic issue(input logic wb, input logic r, input logic w, input logic [31:0] alu,
                         input logic [31:0] st, input logic [3:0] dest);
        int unsigned c;
        int unsigned widx;
        logic        mem, store;
        logic [AW-1:0] lo;
        @(posedge clk);
        #1;
        drive(wb, r, w, alu, st, dest);
        mon_en = 1;
        mem    = r | w;
        store  = w & ~r;
        widx   = ((alu - OFFS) >> 2) % (1 << (AW - 1));
        lo     = AW'(widx * 2);
        c      = 0;
        forever begin
            @(negedge clk);
            if (mem) bus_check(c, store, lo, st);
            if (!freeze) break;
            c++;
            if (c > 100) begin
                $display("FAIL freeze_timeout: got freeze stuck high expected release at %0t", $time);
                break;
            end
        end
        check("freeze_cycles", c, mem ? 2 * W + 1 : 0);
        if (store) ref_word[widx] = st;
        if (r) exp_mrv = ref_read(widx);
        sb.push_back('{wb, r, alu, dest, exp_mrv});
    endtask

    function automatic logic [31:0] rand_mem_addr();
        if ($urandom_range(0, 7) == 0) return 32'h3FC;
        return OFFS + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
    endfunction

    initial begin
        int unsigned c;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        reset_checks("por");

        issue(0, 0, 1, 32'h408, 32'hDEADBEEF, 0);
        issue(1, 1, 0, 32'h408, 32'h0, 3);
        issue(1, 0, 0, 32'h11111111, 32'h0, 1);
        issue(1, 0, 0, 32'h22222222, 32'h0, 2);
        issue(1, 0, 0, 32'h33333333, 32'h0, 3);
        issue(0, 0, 1, 32'h400, 32'hA5A55A5A, 4);
        issue(1, 1, 0, 32'h400, 32'h0, 5);
        issue(0, 0, 1, 32'h3FC, 32'hCAFEF00D, 0);
        issue(1, 1, 0, 32'h3FC, 32'h0, 6);
        issue(1, 1, 1, 32'h40C, 32'h12345678, 7);

        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 3))
                0: issue(1'($urandom), 0, 0, $urandom, $urandom, 4'($urandom));
                1: issue(1'($urandom), 1, 0, rand_mem_addr(), $urandom, 4'($urandom));
                2: issue(1'($urandom), 0, 1, rand_mem_addr(), $urandom, 4'($urandom));
                default: issue(1'($urandom), 1, 1, rand_mem_addr(), $urandom, 4'($urandom));
            endcase
        end

        // Abort a store in its first HI cycle; target word is never read back.
        @(posedge clk);
        #1 drive(0, 0, 1, 32'h600, 32'h0BADF00D, 9);
        c = 0;
        while (c <= W + 1) begin
            @(negedge clk);
            bus_check(c, 1'b1, AW'(32'h100), 32'h0BADF00D);
            c++;
        end
        mon_en = 0;
        rst    = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        exp_mrv = '0;
        @(negedge clk);
        reset_checks("mid_reset");

        issue(0, 0, 1, 32'h410, 32'h13579BDF, 0);
        issue(1, 1, 0, 32'h410, 32'h0, 8);
        issue(1, 0, 0, 32'h44444444, 32'h0, 10);

        @(posedge clk);
        #1 drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1 mon_en = 0;
        check("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
